rem: RTL and testbench
======================

// Module: rem
// PURPOSE
//  - Signed remainder unit of the 3-bit sign-magnitude calculator datapath.
//  - Computes R = A rem B with truncated-division semantics: the remainder takes the sign of the dividend.
//  - Derives zero, even, odd and divide-by-zero status flags.
//  - Output is registered; it sits beside the add/sub/mul/div units and feeds the result mux.
// PARAMETERS
//  - none (operand format fixed: bit2 = sign, bits1:0 = magnitude 0..3)
// PORTS
//  clk        input   1  system clock, rising-edge
//  rst        input   1  synchronous, active-high reset
//  in_valid   input   1  operands valid this cycle
//  A2         input   1  dividend sign (1 = negative)
//  A1,A0      input   1  dividend magnitude bits, MSB..LSB
//  B2         input   1  divisor sign
//  B1,B0      input   1  divisor magnitude bits, MSB..LSB
//  out_valid  output  1  result registers updated from a valid operand pair
//  R2         output  1  remainder sign
//  R1,R0      output  1  remainder magnitude bits
//  ZF         output  1  remainder == 0
//  EF         output  1  remainder even (R0 == 0)
//  OF         output  1  remainder odd (R0 == 1)
//  DZF        output  1  divisor magnitude == 0
// BEHAVIOUR
//  - One clock domain (clk). Reset is synchronous and active-high (rst).
//  - Reset: all outputs are 0 (R=000, ZF=EF=OF=DZF=0, out_valid=0). Reset overrides in_valid in the same cycle.
//  - Latency is 1 cycle. On a rising edge with in_valid=1, the registers capture the results for the current A/B.
//  - out_valid is in_valid delayed by one cycle. When in_valid=0, R and the flags hold their last values.
//  - Magnitudes are ma={A1,A0} and mb={B1,B0}, unsigned 0..3.
//  - Normal case (mb != 0):
//      rm = ma % mb
//      {R1,R0} = rm
//      R2 = A2 if rm != 0, else R2 = 0
//  - The sign of B never affects R.
//  - Negative zero is canonical +0: an input of 100 is treated as 0, and R is never driven to 100.
//  - Divide by zero (mb == 0, B=000 or 100): R = 000 and DZF = 1, regardless of A.
//  - Flags are computed from the registered result:
//      ZF = (rm == 0)
//      EF = ~R0
//      OF = R0
//      DZF = (mb == 0)
//  - EF and OF are always complementary once out_valid has been asserted.
//  - Full truth for mb != 0 (|A| mod |B|):
//      mb=1 -> 0
//      mb=2 -> ma[0]
//      mb=3 -> (ma==3) ? 0 : ma
//  - There is no internal state beyond the output registers; back-to-back in_valid is accepted every cycle.
// STRUCTURE
//  - rem_pkg holds:
//      typedef struct {logic sign; logic [1:0] mag;} sm3_t
//      localparam SM3_ZERO = 3'b000
//      function sm3_canon(), which maps -0 to +0
//  - Sub-module rem_mag_mod: a combinational 2-bit unsigned modulo (ma, mb -> rm, dz), instantiated once.
//  - The top level adds sign selection, flag derivation and the output register stage.
// TESTING
//  - A=011(+3), B=010(+2), in_valid=1 -> next cycle: R=001(+1), ZF=0, EF=0, OF=1, DZF=0, out_valid=1.
//  - A=111(-3), B=010(+2) -> R=101(-1), OF=1. With A=011, B=110(-2) -> R=001(+1): the sign follows A only.
//  - A=010(+2), B=000 and B=100 -> R=000, DZF=1, ZF=1, EF=1, OF=0.
//  - A=100(-0), B=001 -> R=000 (never 100), ZF=1. With A=110(-2), B=010 -> R=000.
//  - Exhaustive: all 64 {A,B} combinations checked against the model one cycle later, including out_valid timing.
//  - Reset: assert rst while in_valid=1 -> outputs are 0 the next cycle. Deassert rst -> a new result appears one cycle after in_valid.

Source files
------------

// File: rtl/rem_pkg.sv
// Shared types and helpers for the 3-bit sign-magnitude remainder unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rem_pkg;

  // Sign-magnitude operand: bit2 = sign, bits1:0 = magnitude 0..3
  typedef struct packed {
    logic       sign;
    logic [1:0] mag;
  } sm3_t;

  localparam logic [2:0] SM3_ZERO = 3'b000;

  // Collapse -0 onto +0 so a negative zero is never produced or propagated
  function automatic sm3_t sm3_canon(sm3_t v);
    sm3_t o;
    o = v;
    if (v.mag == 2'd0) o.sign = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/rem_mag_mod.sv
// Unsigned 2-bit modulo of magnitudes (ma % mb) with divide-by-zero detect.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
module rem_mag_mod (
  input  logic [1:0] ma,
  input  logic [1:0] mb,
  output logic [1:0] rm,
  output logic       dz
);

  // Small enough to enumerate: divisor 1 always leaves 0, divisor 2 leaves
  // the LSB, divisor 3 leaves the dividend unless it is 3 itself.
  always_comb begin
    rm = 2'd0;
    dz = (mb == 2'd0);
    case (mb)
      2'd1:    rm = 2'd0;
      2'd2:    rm = {1'b0, ma[0]};
      2'd3:    rm = (ma == 2'd3) ? 2'd0 : ma;
      default: rm = 2'd0;
    endcase
  end

endmodule

// File: rtl/rem.sv
// Signed remainder R = A rem B (truncated: sign follows dividend) with flags.
// Latency: 1 cycle, out_valid is in_valid delayed; outputs hold when idle.
// Backpressure: none; a new operand pair is accepted every cycle.
module rem
  import rem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  output logic out_valid,
  output logic R2,
  output logic R1,
  output logic R0,
  output logic ZF,
  output logic EF,
  output logic OF,
  output logic DZF
);

  sm3_t       a_in;
  sm3_t       a_c;
  sm3_t       r_raw;
  sm3_t       r_d;
  sm3_t       r_q;
  logic [1:0] rm;
  logic       dz;
  logic       vld_q;
  logic       zf_q;
  logic       ef_q;
  logic       of_q;
  logic       dzf_q;

  // The divisor sign has no effect on a truncated remainder
  logic unused_b_sign;
  assign unused_b_sign = B2;

  assign a_in = {A2, A1, A0};
  assign a_c  = sm3_canon(a_in);

  rem_mag_mod u_mag_mod (
    .ma (a_c.mag),
    .mb ({B1, B0}),
    .rm (rm),
    .dz (dz)
  );

  // Attach the dividend sign to the magnitude remainder; zero stays +0
  always_comb begin
    r_raw.sign = a_c.sign;
    r_raw.mag  = rm;
    r_d        = sm3_canon(r_raw);
    if (dz) r_d = sm3_t'(SM3_ZERO);
  end

  // Result and flag registers; load only on a valid operand pair
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      r_q   <= sm3_t'(SM3_ZERO);
      zf_q  <= 1'b0;
      ef_q  <= 1'b0;
      of_q  <= 1'b0;
      dzf_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        r_q   <= r_d;
        zf_q  <= (r_d.mag == 2'd0);
        ef_q  <= ~r_d.mag[0];
        of_q  <= r_d.mag[0];
        dzf_q <= dz;
      end
    end
  end

  assign out_valid = vld_q;
  assign R2        = r_q.sign;
  assign R1        = r_q.mag[1];
  assign R0        = r_q.mag[0];
  assign ZF        = zf_q;
  assign EF        = ef_q;
  assign OF        = of_q;
  assign DZF       = dzf_q;

endmodule

// File: tb/tb_rem.sv
// Scoreboard bench for rem: stimulus pushes model results, monitor compares.
// Latency: checks out_valid exactly one cycle after an accepted in_valid.
// Backpressure: none exercised; idle gaps check that outputs hold.
module tb_rem;

  typedef struct packed {
    logic [2:0] r;
    logic       zf;
    logic       ef;
    logic       of;
    logic       dzf;
  } exp_t;

  logic clk, rst, in_valid;
  logic A2, A1, A0, B2, B1, B0;
  logic out_valid, R2, R1, R0, ZF, EF, OF, DZF;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  rem dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .A2(A2), .A1(A1), .A0(A0), .B2(B2), .B1(B1), .B0(B0),
    .out_valid(out_valid), .R2(R2), .R1(R1), .R0(R0),
    .ZF(ZF), .EF(EF), .OF(OF), .DZF(DZF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: signed integer arithmetic; SV % truncates toward zero
  function automatic exp_t model(logic [2:0] a, logic [2:0] b);
    int   av, bv, r;
    exp_t e;
    av = int'(a[1:0]);
    if (a[2]) av = -av;
    bv = int'(b[1:0]);
    if (b[2]) bv = -bv;
    e = '0;
    if (bv == 0) begin
      e.dzf = 1'b1;
      r = 0;
    end else begin
      r = av % bv;
    end
    e.r[2]   = (r < 0);
    e.r[1:0] = 2'((r < 0) ? -r : r);
    e.zf     = (r == 0);
    e.ef     = ~e.r[0];
    e.of     = e.r[0];
    return e;
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    {A2, A1, A0} = a;
    {B2, B1, B0} = b;
    sb_q.push_back(model(a, b));
  endtask

  task automatic idle();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    {A2, A1, A0} = 3'($urandom);
    {B2, B1, B0} = 3'($urandom);
  endtask

  task automatic do_reset(input logic with_valid, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1;
      in_valid = with_valid;
      {A2, A1, A0} = 3'b011;
      {B2, B1, B0} = 3'b010;
    end
  endtask

  // Monitor: tracks what the outputs must show every cycle
  initial begin
    exp_t cur;
    logic rst_s, vld_s, exp_v;
    cur = '0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      vld_s = in_valid;
      #1;
      exp_v = vld_s && !rst_s;
      chk("out_valid", {3'b0, out_valid}, {3'b0, exp_v});
      if (rst_s) begin
        cur = '0;
      end else if (exp_v) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_underflow", 4'd1, 4'd0);
        end else begin
          cur = sb_q.pop_front();
        end
      end
      chk("R",   {1'b0, R2, R1, R0}, {1'b0, cur.r});
      chk("ZF",  {3'b0, ZF},  {3'b0, cur.zf});
      chk("EF",  {3'b0, EF},  {3'b0, cur.ef});
      chk("OF",  {3'b0, OF},  {3'b0, cur.of});
      chk("DZF", {3'b0, DZF}, {3'b0, cur.dzf});
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    {A2, A1, A0, B2, B1, B0} = 6'b0;
    do_reset(1'b0, 3);

    // Directed cases
    issue(3'b011, 3'b010);
    issue(3'b111, 3'b010);
    issue(3'b011, 3'b110);
    issue(3'b010, 3'b000);
    issue(3'b010, 3'b100);
    issue(3'b100, 3'b001);
    issue(3'b110, 3'b010);
    idle();
    idle();

    // Exhaustive, back-to-back
    for (int i = 0; i < 64; i++) begin
      logic [5:0] ab;
      ab = 6'(i);
      issue(ab[5:3], ab[2:0]);
    end
    idle();

    // Random with gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idle();
      else issue(3'($urandom), 3'($urandom));
    end

    // Reset while in_valid is high, then recovery
    issue(3'b111, 3'b011);
    do_reset(1'b1, 2);
    idle();
    issue(3'b111, 3'b010);
    idle();
    idle();

    @(negedge clk);
    chk("scoreboard_drained", 4'(sb_q.size()), 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
